// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin packet arbiter.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NumReq = 4;
    localparam int SelW   = 2;

endpackage

// File: rtl/mux4.sv
// Four-input data selector shared by the packet requesters.
// Latency: combinational. Backpressure: none, pure datapath.
module mux4 #(
    parameter int Size = 8
) (
    input  logic [1:0]      select,
    input  logic [Size-1:0] data_i00,
    input  logic [Size-1:0] data_i01,
    input  logic [Size-1:0] data_i02,
    input  logic [Size-1:0] data_i03,
    output logic [Size-1:0] data_o
);

    always_comb begin
        data_o = data_i00;
        case (select)
            2'd0: data_o = data_i00;
            2'd1: data_o = data_i01;
            2'd2: data_o = data_i02;
            2'd3: data_o = data_i03;
            default: data_o = data_i00;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Round-robin picker: first set request bit scanning from pointer upward, modulo 4.
// Latency: combinational. Backpressure: none.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] request,
    input  logic [SelW-1:0]   pointer,
    output logic [SelW-1:0]   winner,
    output logic              any
);

    logic [SelW-1:0] idx;

    // Walk the scan order backwards so the candidate closest to pointer is written last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = pointer;
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = pointer + SelW'(k);
            if (request[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters per packet onto a shared mux4.
// Latency: 1 cycle request-to-grant, then combinational valid/ready pass-through.
// Backpressure: ready_i is forwarded only to the granted requester; one idle bubble between packets.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int Size     = 8,
    parameter int MaxBeats = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      valid_i,
    input  logic [3:0]      last_i,
    input  logic [Size-1:0] data_i00,
    input  logic [Size-1:0] data_i01,
    input  logic [Size-1:0] data_i02,
    input  logic [Size-1:0] data_i03,
    output logic [3:0]      ready_o,
    output logic [Size-1:0] data_o,
    output logic            valid_o,
    output logic            last_o,
    input  logic            ready_i,
    output logic [1:0]      select_o,
    output logic            busy_o,
    output logic            overrun_o
);

    localparam int BeatW = $clog2(MaxBeats + 1);
    localparam logic [BeatW-1:0] BeatMax = BeatW'(MaxBeats);

    state_t          state_q, state_d;
    logic [SelW-1:0] pointer_q, pointer_d;
    logic [SelW-1:0] select_q, select_d;
    logic [BeatW-1:0] beats_q, beats_d;
    logic            overrun_q, overrun_d;

    logic [SelW-1:0] winner;
    logic            any;
    logic            xfer;
    logic [BeatW-1:0] beats_inc;

    rr_pick4 u_pick (
        .request (valid_i),
        .pointer (pointer_q),
        .winner  (winner),
        .any     (any)
    );

    mux4 #(.Size(Size)) u_mux (
        .select   (select_q),
        .data_i00 (data_i00),
        .data_i01 (data_i01),
        .data_i02 (data_i02),
        .data_i03 (data_i03),
        .data_o   (data_o)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pointer_q <= '0;
            select_q  <= '0;
            beats_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            select_q  <= select_d;
            beats_q   <= beats_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        select_d  = select_q;
        beats_d   = beats_q;
        overrun_d = overrun_q;
        valid_o   = 1'b0;
        last_o    = 1'b0;
        ready_o   = '0;
        xfer      = 1'b0;
        beats_inc = beats_q + BeatW'(1);

        case (state_q)
            IDLE: begin
                if (any) begin
                    select_d = winner;
                    beats_d  = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                valid_o           = valid_i[select_q];
                last_o            = last_i[select_q];
                ready_o[select_q] = ready_i;
                xfer              = valid_i[select_q] && ready_i;
                if (xfer) begin
                    beats_d = beats_inc;
                    // A last beat landing exactly on the cap is a clean release, not an overrun.
                    if (last_i[select_q] || beats_inc == BeatMax) begin
                        state_d   = IDLE;
                        pointer_d = select_q + SelW'(1);
                        if (!last_i[select_q]) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign select_o  = select_q;
    assign busy_o    = (state_q == GRANT);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with the beat cap lowered to 4.
module tb_mux4_rr_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] valid_i = '0;
    logic [3:0] last_i = '0;
    logic [7:0] data_i00 = 8'hA0;
    logic [7:0] data_i01 = 8'hB1;
    logic [7:0] data_i02 = 8'hC2;
    logic [7:0] data_i03 = 8'hD3;
    logic [3:0] ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       last_o;
    logic       ready_i = 1'b1;
    logic [1:0] select_o;
    logic       busy_o;
    logic       overrun_o;

    int errors = 0;
    int checks = 0;

    mux4_rr_arbiter #(.Size(8), .MaxBeats(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .data_i00  (data_i00),
        .data_i01  (data_i01),
        .data_i02  (data_i02),
        .data_i03  (data_i03),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .last_o    (last_o),
        .ready_i   (ready_i),
        .select_o  (select_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_i = 4'b0000;
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++;
        if (ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ready_o); end
        checks++;
        if (valid_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid_overrun got %b%b exp 00", valid_o, overrun_o);
        end
        checks++;
        if (select_o !== 2'd0 || data_o !== 8'hA0) begin
            errors++; $display("FAIL reset_sel_data got %0d/%h exp 0/a0", select_o, data_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        valid_i = 4'b0101;
        last_i  = 4'b0101;
        ready_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b exp 0", valid_o); end
        tick();
        checks++;
        if (select_o !== 2'd0 || data_o !== 8'hA0 || ready_o !== 4'b0001 || valid_o !== 1'b1 || last_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_grant0 got sel=%0d d=%h rdy=%b v=%b l=%b exp 0 a0 0001 1 1",
                     select_o, data_o, ready_o, valid_o, last_o);
        end
        tick();
        valid_i = 4'b0100;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 4'b0000 || valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_bubble got busy=%b rdy=%b v=%b exp 0 0000 0", busy_o, ready_o, valid_o);
        end
        tick();
        checks++;
        if (select_o !== 2'd2 || data_o !== 8'hC2 || ready_o !== 4'b0100) begin
            errors++; $display("FAIL basic_grant2 got sel=%0d d=%h rdy=%b exp 2 c2 0100", select_o, data_o, ready_o);
        end
        tick();
        valid_i = 4'b1101;
        last_i  = 4'b1101;
        tick();
        checks++;
        if (select_o !== 2'd3 || data_o !== 8'hD3) begin
            errors++; $display("FAIL basic_pointer3 got sel=%0d d=%h exp 3 d3", select_o, data_o);
        end
        tick();
        valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_all_four();
        logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_rdy;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_rdy = 4'b0001 << exp_sel[i];
            checks++;
            if (busy_o !== 1'b1 || select_o !== exp_sel[i] || ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL all4_grant%0d got busy=%b sel=%0d rdy=%b exp 1 %0d %b",
                         i, busy_o, select_o, ready_o, exp_sel[i], exp_rdy);
            end
            tick();
            checks++;
            if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++; $display("FAIL all4_bubble%0d got busy=%b v=%b exp 0 0", i, busy_o, valid_o);
            end
        end
        valid_i = 4'b0000;
    endtask

    task automatic test_stall();
        valid_i = 4'b0010;
        last_i  = 4'b0000;
        ready_i = 1'b1;
        tick();
        checks++;
        if (select_o !== 2'd1 || data_o !== 8'hB1) begin
            errors++; $display("FAIL stall_grant got sel=%0d d=%h exp 1 b1", select_o, data_o);
        end
        tick();
        ready_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 4'b0000 || select_o !== 2'd1) begin
            errors++; $display("FAIL stall_hold got v=%b rdy=%b sel=%0d exp 1 0000 1", valid_o, ready_o, select_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || valid_o !== 1'b1 || select_o !== 2'd1) begin
            errors++; $display("FAIL stall_no_xfer got busy=%b v=%b sel=%0d exp 1 1 1", busy_o, valid_o, select_o);
        end
        ready_i = 1'b1;
        tick();
        last_i = 4'b0010;
        #1;
        checks++;
        if (last_o !== 1'b1 || ready_o !== 4'b0010 || busy_o !== 1'b1) begin
            errors++; $display("FAIL stall_beat3 got l=%b rdy=%b busy=%b exp 1 0010 1", last_o, ready_o, busy_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++; $display("FAIL stall_release got busy=%b ovr=%b exp 0 0", busy_o, overrun_o);
        end
        valid_i = 4'b0000;
        last_i  = 4'b0000;
    endtask

    task automatic test_overrun();
        logic [1:0] exp_sel [3] = '{2'd0, 2'd1, 2'd2};
        valid_i = 4'b1000;
        last_i  = 4'b0000;
        ready_i = 1'b1;
        tick();
        checks++;
        if (select_o !== 2'd3) begin errors++; $display("FAIL ovr_grant3 got %0d exp 3", select_o); end
        for (int b = 1; b <= 4; b++) begin
            tick();
            if (b == 3) begin
                checks++;
                if (busy_o !== 1'b1 || overrun_o !== 1'b0) begin
                    errors++; $display("FAIL ovr_beat3 got busy=%b ovr=%b exp 1 0", busy_o, overrun_o);
                end
            end
        end
        checks++;
        if (busy_o !== 1'b0 || overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_release got busy=%b ovr=%b exp 0 1", busy_o, overrun_o);
        end
        valid_i = 4'b1111;
        last_i  = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (select_o !== exp_sel[i] || busy_o !== 1'b1) begin
                errors++; $display("FAIL ovr_others%0d got sel=%0d busy=%b exp %0d 1", i, select_o, busy_o, exp_sel[i]);
            end
            tick();
        end
        valid_i = 4'b1000;
        tick();
        checks++;
        if (select_o !== 2'd3 || overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_regrant3 got sel=%0d ovr=%b exp 3 1", select_o, overrun_o);
        end
        tick();
        last_i = 4'b1000;
        tick();
        checks++;
        if (busy_o !== 1'b0 || overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky got busy=%b ovr=%b exp 0 1", busy_o, overrun_o);
        end
        valid_i = 4'b0000;
        last_i  = 4'b0000;
    endtask

    task automatic test_reset_mid();
        valid_i = 4'b0100;
        last_i  = 4'b0000;
        ready_i = 1'b1;
        tick();
        checks++;
        if (select_o !== 2'd2) begin errors++; $display("FAIL rmid_grant got %0d exp 2", select_o); end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 4'b0000 || overrun_o !== 1'b0 || select_o !== 2'd0) begin
            errors++;
            $display("FAIL rmid_state got busy=%b rdy=%b ovr=%b sel=%0d exp 0 0000 0 0",
                     busy_o, ready_o, overrun_o, select_o);
        end
        reset   = 1'b0;
        valid_i = 4'b1111;
        tick();
        checks++;
        if (select_o !== 2'd0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL rmid_pointer0 got sel=%0d busy=%b exp 0 1", select_o, busy_o);
        end
        last_i = 4'b1111;
        tick();
        valid_i = 4'b0000;
        last_i  = 4'b0000;
    endtask

    task automatic test_hold();
        valid_i = 4'b0010;
        last_i  = 4'b0000;
        ready_i = 1'b1;
        tick();
        checks++;
        if (select_o !== 2'd1) begin errors++; $display("FAIL hold_grant got %0d exp 1", select_o); end
        tick();
        valid_i = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (busy_o !== 1'b1 || select_o !== 2'd1 || valid_o !== 1'b0 || ready_o !== 4'b0010) begin
                errors++;
                $display("FAIL hold_cycle%0d got busy=%b sel=%0d v=%b rdy=%b exp 1 1 0 0010",
                         c, busy_o, select_o, valid_o, ready_o);
            end
            tick();
        end
        valid_i = 4'b0011;
        last_i  = 4'b0010;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL hold_release got %b exp 0", busy_o); end
        tick();
        checks++;
        if (select_o !== 2'd0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL hold_next got sel=%0d busy=%b exp 0 1", select_o, busy_o);
        end
        last_i = 4'b0011;
        tick();
        valid_i = 4'b0000;
        last_i  = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_four();
        test_stall();
        test_overrun();
        test_reset_mid();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
